riscv_hwloop_regs: RTL and testbench

Storage for the hardware-loop register sets: start address, end address and iteration counter per loop.
- Written by the ID stage when it executes lp.start / lp.end / lp.count / lp.setup(i) instructions.
- Decremented on request from the hardware-loop controller each time the fetch PC hits a loop end.
- Exports all register sets to that controller every cycle.
- Also exports a per-loop "decrement in flight" flag, which the controller uses to resolve the counter==2 corner case.

---
 rtl/riscv_hwloop_regs_pkg.sv | 11 +
 rtl/riscv_hwloop_reg_set.sv | 72 +++++++
 rtl/riscv_hwloop_regs.sv | 50 +++++
 tb/tb_riscv_hwloop_regs.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/riscv_hwloop_regs_pkg.sv
// Shared constants for the hardware-loop register file: write-enable bit
// positions and the register width.
package riscv_hwloop_regs_pkg;

   localparam int HWLP_WE_START = 0;
   localparam int HWLP_WE_END   = 1;
   localparam int HWLP_WE_CNT   = 2;

   localparam int HWLP_DATA_W   = 32;

endpackage

// File: rtl/riscv_hwloop_reg_set.sv
// One hardware-loop register set: start/end addresses, a saturating
// iteration counter and the "decrement still in ID" flag.
module riscv_hwloop_reg_set
   import riscv_hwloop_regs_pkg::*;
(
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   start_we_i,
   input  logic                   end_we_i,
   input  logic                   cnt_we_i,
   input  logic [HWLP_DATA_W-1:0] start_data_i,
   input  logic [HWLP_DATA_W-1:0] end_data_i,
   input  logic [HWLP_DATA_W-1:0] cnt_data_i,
   input  logic                   dec_i,
   input  logic                   id_valid_i,
   output logic [HWLP_DATA_W-1:0] start_o,
   output logic [HWLP_DATA_W-1:0] end_o,
   output logic [HWLP_DATA_W-1:0] cnt_o,
   output logic                   dec_id_o
);

   logic [HWLP_DATA_W-1:0] start_q, start_d;
   logic [HWLP_DATA_W-1:0] end_q,   end_d;
   logic [HWLP_DATA_W-1:0] cnt_q,   cnt_d;
   logic                   flag_q,  flag_d;
   logic                   dec_applied;

   function automatic logic [HWLP_DATA_W-1:0] sat_dec(input logic [HWLP_DATA_W-1:0] v);
      return (v == '0) ? '0 : v - 1'b1;
   endfunction

   assign dec_applied = dec_i && (cnt_q != '0);

   always_comb begin
      start_d = start_q;
      end_d   = end_q;
      cnt_d   = cnt_q;
      flag_d  = flag_q;

      if (start_we_i) start_d = start_data_i;
      if (end_we_i)   end_d   = end_data_i;

      // A counter write overrides a decrement landing on the same edge.
      if (cnt_we_i)         cnt_d = cnt_data_i;
      else if (dec_applied) cnt_d = sat_dec(cnt_q);

      if (cnt_we_i && !dec_i)         flag_d = 1'b0;
      if (id_valid_i && !dec_applied) flag_d = 1'b0;
      // Setting wins: the next loop-end instruction enters ID as the old one leaves.
      if (dec_applied)                flag_d = 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         start_q <= '0;
         end_q   <= '0;
         cnt_q   <= '0;
         flag_q  <= 1'b0;
      end else begin
         start_q <= start_d;
         end_q   <= end_d;
         cnt_q   <= cnt_d;
         flag_q  <= flag_d;
      end
   end

   assign start_o  = start_q;
   assign end_o    = end_q;
   assign cnt_o    = cnt_q;
   assign dec_id_o = flag_q;

endmodule

// File: rtl/riscv_hwloop_regs.sv
// Hardware-loop register file: N_REGS sets written by the ID stage and
// decremented by the loop controller; all outputs are registered.
module riscv_hwloop_regs
   import riscv_hwloop_regs_pkg::*;
#(
   parameter int N_REGS     = 2,
   parameter int N_REG_BITS = (N_REGS > 1) ? $clog2(N_REGS) : 1
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [31:0]             hwlp_start_data_i,
   input  logic [31:0]             hwlp_end_data_i,
   input  logic [31:0]             hwlp_cnt_data_i,
   input  logic [2:0]              hwlp_we_i,
   input  logic [N_REG_BITS-1:0]   hwlp_regid_i,
   input  logic                    valid_i,
   input  logic [N_REGS-1:0]       hwlp_dec_cnt_i,
   input  logic                    id_valid_i,
   output logic [N_REGS*32-1:0]    hwlp_start_addr_o,
   output logic [N_REGS*32-1:0]    hwlp_end_addr_o,
   output logic [N_REGS*32-1:0]    hwlp_counter_o,
   output logic [N_REGS-1:0]       hwlp_dec_cnt_id_o
);

   for (genvar g = 0; g < N_REGS; g++) begin : gen_set
      // An out-of-range regid matches no set, so such writes fall away.
      localparam logic [N_REG_BITS-1:0] SET_ID = N_REG_BITS'(g);

      logic sel;
      assign sel = valid_i && (hwlp_regid_i == SET_ID);

      riscv_hwloop_reg_set u_set (
         .clk          (clk),
         .rst_n        (rst_n),
         .start_we_i   (sel && hwlp_we_i[HWLP_WE_START]),
         .end_we_i     (sel && hwlp_we_i[HWLP_WE_END]),
         .cnt_we_i     (sel && hwlp_we_i[HWLP_WE_CNT]),
         .start_data_i (hwlp_start_data_i),
         .end_data_i   (hwlp_end_data_i),
         .cnt_data_i   (hwlp_cnt_data_i),
         .dec_i        (hwlp_dec_cnt_i[g]),
         .id_valid_i   (id_valid_i),
         .start_o      (hwlp_start_addr_o[g*32 +: 32]),
         .end_o        (hwlp_end_addr_o[g*32 +: 32]),
         .cnt_o        (hwlp_counter_o[g*32 +: 32]),
         .dec_id_o     (hwlp_dec_cnt_id_o[g])
      );
   end

endmodule

// File: tb/tb_riscv_hwloop_regs.sv
// Directed bench for riscv_hwloop_regs with two register sets.
module tb_riscv_hwloop_regs;

   localparam int NR = 2;
   localparam int NB = 1;

   logic            clk = 1'b0;
   logic            rst_n;
   logic [31:0]     start_data, end_data, cnt_data;
   logic [2:0]      we;
   logic [NB-1:0]   regid;
   logic            valid;
   logic [NR-1:0]   dec;
   logic            id_valid;
   logic [NR*32-1:0] start_o, end_o, cnt_o;
   logic [NR-1:0]   flag_o;

   int n_vec = 0;
   int n_bad = 0;

   riscv_hwloop_regs #(.N_REGS(NR), .N_REG_BITS(NB)) dut (
      .clk               (clk),
      .rst_n             (rst_n),
      .hwlp_start_data_i (start_data),
      .hwlp_end_data_i   (end_data),
      .hwlp_cnt_data_i   (cnt_data),
      .hwlp_we_i         (we),
      .hwlp_regid_i      (regid),
      .valid_i           (valid),
      .hwlp_dec_cnt_i    (dec),
      .id_valid_i        (id_valid),
      .hwlp_start_addr_o (start_o),
      .hwlp_end_addr_o   (end_o),
      .hwlp_counter_o    (cnt_o),
      .hwlp_dec_cnt_id_o (flag_o)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [2:0]  we;
      logic        regid;
      logic        valid;
      logic [31:0] s, e, c;
      logic [1:0]  dec;
      logic        idv;
      logic [31:0] xs0, xs1, xe0, xe1, xc0, xc1;
      logic [1:0]  xf;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(input logic [2:0] we_v, input logic rid, input logic vld,
                               input logic [31:0] s, input logic [31:0] e, input logic [31:0] c,
                               input logic [1:0] d, input logic idv,
                               input logic [31:0] xs0, input logic [31:0] xs1,
                               input logic [31:0] xe0, input logic [31:0] xe1,
                               input logic [31:0] xc0, input logic [31:0] xc1,
                               input logic [1:0] xf);
      vec_t v;
      v.we = we_v; v.regid = rid; v.valid = vld; v.s = s; v.e = e; v.c = c;
      v.dec = d; v.idv = idv;
      v.xs0 = xs0; v.xs1 = xs1; v.xe0 = xe0; v.xe1 = xe1; v.xc0 = xc0; v.xc1 = xc1; v.xf = xf;
      return v;
   endfunction

   task automatic check_state(input string name,
                              input logic [31:0] xs0, input logic [31:0] xs1,
                              input logic [31:0] xe0, input logic [31:0] xe1,
                              input logic [31:0] xc0, input logic [31:0] xc1,
                              input logic [1:0] xf);
      n_vec++;
      if ({start_o, end_o, cnt_o, flag_o} !== {xs1, xs0, xe1, xe0, xc1, xc0, xf}) begin
         n_bad++;
         $display("FAIL %s: got start=%h end=%h cnt=%h flag=%b, want start=%h_%h end=%h_%h cnt=%h_%h flag=%b",
                  name, start_o, end_o, cnt_o, flag_o, xs1, xs0, xe1, xe0, xc1, xc0, xf);
      end
   endtask

   task automatic idle();
      we = 3'b000; regid = '0; valid = 1'b0; dec = '0; id_valid = 1'b0;
      start_data = '0; end_data = '0; cnt_data = '0;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      // we    rid vld  start     end       cnt       dec   idv  | s0      s1     e0      e1     c0  c1    flag
      vecs.push_back(mk(3'b111, 1, 1, 32'h100, 32'h120, 32'd5,  2'b00, 0, 0, 32'h100, 0, 32'h120, 0, 5, 2'b00));
      vecs.push_back(mk(3'b111, 1, 0, 32'hAAA, 32'hBBB, 32'd77, 2'b00, 0, 0, 32'h100, 0, 32'h120, 0, 5, 2'b00));
      vecs.push_back(mk(3'b100, 0, 1, 0, 0, 32'd3,              2'b00, 0, 0, 32'h100, 0, 32'h120, 3, 5, 2'b00));
      vecs.push_back(mk(3'b000, 0, 0, 0, 0, 0,                  2'b01, 0, 0, 32'h100, 0, 32'h120, 2, 5, 2'b01));
      vecs.push_back(mk(3'b000, 0, 0, 0, 0, 0,                  2'b01, 0, 0, 32'h100, 0, 32'h120, 1, 5, 2'b01));
      vecs.push_back(mk(3'b000, 0, 0, 0, 0, 0,                  2'b01, 0, 0, 32'h100, 0, 32'h120, 0, 5, 2'b01));
      vecs.push_back(mk(3'b000, 0, 0, 0, 0, 0,                  2'b01, 0, 0, 32'h100, 0, 32'h120, 0, 5, 2'b01));
      vecs.push_back(mk(3'b000, 0, 0, 0, 0, 0,                  2'b00, 1, 0, 32'h100, 0, 32'h120, 0, 5, 2'b00));
      vecs.push_back(mk(3'b100, 0, 1, 0, 0, 32'd7,              2'b00, 0, 0, 32'h100, 0, 32'h120, 7, 5, 2'b00));
      vecs.push_back(mk(3'b100, 0, 1, 0, 0, 32'd9,              2'b01, 0, 0, 32'h100, 0, 32'h120, 9, 5, 2'b01));
      vecs.push_back(mk(3'b000, 0, 0, 0, 0, 0,                  2'b00, 1, 0, 32'h100, 0, 32'h120, 9, 5, 2'b00));
      vecs.push_back(mk(3'b000, 0, 0, 0, 0, 0,                  2'b01, 1, 0, 32'h100, 0, 32'h120, 8, 5, 2'b01));
      vecs.push_back(mk(3'b001, 0, 1, 32'h203, 0, 0,            2'b01, 0, 32'h203, 32'h100, 0, 32'h120, 7, 5, 2'b01));
      vecs.push_back(mk(3'b010, 0, 1, 0, 32'h3FF, 0,            2'b00, 0, 32'h203, 32'h100, 32'h3FF, 32'h120, 7, 5, 2'b01));
      vecs.push_back(mk(3'b100, 0, 1, 0, 0, 32'd4,              2'b00, 0, 32'h203, 32'h100, 32'h3FF, 32'h120, 4, 5, 2'b00));
      vecs.push_back(mk(3'b000, 0, 0, 0, 0, 0,                  2'b10, 0, 32'h203, 32'h100, 32'h3FF, 32'h120, 4, 4, 2'b10));
      vecs.push_back(mk(3'b000, 0, 0, 0, 0, 0,                  2'b11, 0, 32'h203, 32'h100, 32'h3FF, 32'h120, 3, 3, 2'b11));
      vecs.push_back(mk(3'b100, 1, 1, 0, 0, 32'h10,             2'b01, 0, 32'h203, 32'h100, 32'h3FF, 32'h120, 2, 32'h10, 2'b01));
      vecs.push_back(mk(3'b111, 0, 0, 32'hDEAD, 32'hBEEF, 32'd99, 2'b00, 1, 32'h203, 32'h100, 32'h3FF, 32'h120, 2, 32'h10, 2'b00));
      vecs.push_back(mk(3'b000, 0, 0, 0, 0, 0,                  2'b01, 0, 32'h203, 32'h100, 32'h3FF, 32'h120, 1, 32'h10, 2'b01));

      // Reset held with inputs toggling.
      rst_n = 1'b0;
      idle();
      for (int i = 0; i < 4; i++) begin
         we = 3'($urandom); regid = NB'($urandom); valid = 1'b1; dec = NR'($urandom);
         id_valid = 1'($urandom);
         start_data = $urandom; end_data = $urandom; cnt_data = $urandom;
         step();
         check_state($sformatf("reset_hold%0d", i), 0, 0, 0, 0, 0, 0, 2'b00);
      end
      idle();
      rst_n = 1'b1;
      step();
      step();
      check_state("reset_release", 0, 0, 0, 0, 0, 0, 2'b00);

      foreach (vecs[i]) begin
         we = vecs[i].we; regid = vecs[i].regid; valid = vecs[i].valid;
         start_data = vecs[i].s; end_data = vecs[i].e; cnt_data = vecs[i].c;
         dec = vecs[i].dec; id_valid = vecs[i].idv;
         step();
         check_state($sformatf("vec%0d", i), vecs[i].xs0, vecs[i].xs1, vecs[i].xe0, vecs[i].xe1,
                     vecs[i].xc0, vecs[i].xc1, vecs[i].xf);
      end

      // Counter write of 5 to set 1, then one decrement -> counter1=4 with flag1 set.
      idle();
      we = 3'b100; regid = 1'b1; valid = 1'b1; cnt_data = 32'd5;
      step();
      check_state("pre_rst_wr", 32'h203, 32'h100, 32'h3FF, 32'h120, 1, 5, 2'b01);
      idle();
      dec = 2'b10;
      step();
      check_state("pre_rst_dec", 32'h203, 32'h100, 32'h3FF, 32'h120, 1, 4, 2'b11);

      // Asynchronous reset in mid-cycle: outputs must clear before the next edge.
      idle();
      #2;
      rst_n = 1'b0;
      #1;
      check_state("async_rst", 0, 0, 0, 0, 0, 0, 2'b00);
      step();
      rst_n = 1'b1;
      step();
      check_state("post_rst", 0, 0, 0, 0, 0, 0, 2'b00);

      // Decrement on a zero counter after reset: no wrap and no flag.
      dec = 2'b11;
      step();
      check_state("dec_zero", 0, 0, 0, 0, 0, 0, 2'b00);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
